alu_muldiv_unit: RTL
====================

// Module: alu_muldiv_unit
// PURPOSE
//  EX-stage ALU control plus an iterative HI/LO multiply/divide unit for the pipelined MIPS core.
//  Decodes aluop/func into alucontrol/shift as before, and adds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
//  The unit runs a WIDTH-cycle shift-add or restoring-divide FSM and stalls the pipeline via stall_e until HI/LO are final.
// PARAMETERS
//  WIDTH  32  datapath width of srca/srcb/HI/LO; must be >= 4
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous reset, active low
//  aluop         in   3      main-decoder ALU op class
//  func          in   6      R-type funct field
//  valid_e       in   1      EX holds a real instruction (0 = bubble)
//  flush_e       in   1      kill the EX instruction this cycle
//  srca          in   WIDTH  rs operand (dividend / multiplicand)
//  srcb          in   WIDTH  rt operand (divisor / multiplier)
//  alucontrol    out  3      ALU function select
//  shift         out  1      1 = shamt shift, 0 = register/variable shift or non-shift
//  mf_sel        out  1      1 = EX result comes from mf_result (MFHI/MFLO)
//  mf_result     out  WIDTH  HI for MFHI, LO for MFLO, else 0
//  stall_e       out  1      hold IF/ID/EX; EX instruction must not retire
//  md_busy       out  1      FSM not in IDLE
//  div_by_zero   out  1      one-cycle pulse in DONE of a DIV/DIVU with srcb==0
//  hi, lo        out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
//  Decode (combinational): aluop 000 add 010; 001 sub 110; 011 or 001; 100 and 000; 101 slt 111; 110/111 -> 010, shift 0.
//   aluop 010, func: 000000 011/1; 100000 010/0; 100010 110/0; 100100 000/0; 100101 001/0; 101010 111/0;
//   000100 011/0; 000011 100/1; 000111 100/0; 000010 101/1; 000110 101/0; any other func 011/0.
//   Muldiv funcs (aluop 010): 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO,
//   010001 MTHI, 010011 MTLO. For these alucontrol=010, shift=0. mf_sel=1 only for MFHI/MFLO.
//  start = valid_e & !flush_e & state==IDLE & op in {MULT,MULTU,DIV,DIVU}.
//  FSM IDLE -> CALC (on start; latch |srca|,|srcb| for signed ops, raw for unsigned, and result signs; count=0)
//   CALC: one shift-add / restoring-subtract step per cycle; after WIDTH steps -> FIX.
//   FIX: apply signs: product negated if sa^sb; quotient negated if sa^sb, remainder takes sign of sa. -> DONE.
//   DONE: write HI/LO (mult: HI=upper, LO=lower of 2*WIDTH product; div: LO=quotient, HI=remainder) -> IDLE.
//  stall_e = start | state==CALC | state==FIX. Stall length = WIDTH+2 cycles; stall_e=0 in DONE so the op retires.
//  DONE never restarts (same instruction still in EX); operand changes after start are ignored.
//  Div by zero: full latency kept; LO=all-ones, HI=srca(dividend); div_by_zero=1 in DONE only.
//  Signed MIN / -1: LO=MIN, HI=0 (natural wrap of abs arithmetic), no flag.
//  MTHI/MTLO: write HI/LO from srca at edge when valid_e & !flush_e & state==IDLE. MFHI/MFLO read current HI/LO;
//   an MF in EX during DONE sees the new values (DONE write is visible combinationally via bypass).
//  flush_e in CALC/FIX: abort to IDLE next edge, HI/LO unchanged, stall_e falls with state.
//  Reset (async, rst_n=0): state IDLE, count 0, hi=lo=0, stall_e=md_busy=div_by_zero=0 immediately, mid-op discarded.
//  Multiplier/divider internals use a 2*WIDTH+1 bit accumulator; no output X on bubbles (valid_e=0 gives no writes).
// TESTING (WIDTH=32)
//  Decode sweep all aluop x listed funcs -> alucontrol/shift per table; func 111111 -> 011/0.
//  MULT srca=FFFFFFFE srcb=00000003 -> stall_e high 34 cycles, then HI=FFFFFFFF LO=FFFFFFFA; MULTU same -> HI=00000002.
//  DIV srca=FFFFFFF9(-7) srcb=00000002 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU 7/0 -> LO=FFFFFFFF HI=00000007, div_by_zero 1 cycle.
//  MTHI 12345678 then MFHI next cycle -> mf_sel=1, mf_result=12345678; MFLO in DONE of MULT -> new LO.
//  rst_n low at CALC count 10 -> state IDLE, stall_e 0, hi=lo=0 without clock edge; flush_e in FIX -> HI/LO unchanged.
//  Back-to-back MULT then DIV -> second start only after DONE->IDLE; no lost or duplicated HI/LO write.

Source files
------------

// File: rtl/alu_muldiv_unit_if.sv
// EX-stage bus between the pipeline and the ALU-control / HI-LO multiply-divide unit.
// master drives the instruction fields and operands; slave returns decode, stall and HI/LO.
interface alu_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [2:0]       aluop;
  logic [5:0]       func;
  logic             valid_e;
  logic             flush_e;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [2:0]       alucontrol;
  logic             shift;
  logic             mf_sel;
  logic [WIDTH-1:0] mf_result;
  logic             stall_e;
  logic             md_busy;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output aluop, func, valid_e, flush_e, srca, srcb,
    input  alucontrol, shift, mf_sel, mf_result, stall_e, md_busy, div_by_zero, hi, lo
  );

  modport slave (
    input  aluop, func, valid_e, flush_e, srca, srcb,
    output alucontrol, shift, mf_sel, mf_result, stall_e, md_busy, div_by_zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU control decode plus an iterative HI/LO unit: WIDTH-step shift-add multiply or
// restoring divide on magnitudes, sign fix-up, then a single HI/LO write while the pipeline stalls.
module alu_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  alu_muldiv_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH + 1;

  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMtlo  = 6'b010011;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [AccW-1:0]  acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div_q;
  logic             sa_q;
  logic             sb_q;

  // Instruction decode
  logic is_r, is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_md, is_signed, ex_ok, start;

  assign is_r      = (bus.aluop == 3'b010);
  assign is_mult   = is_r & (bus.func == FnMult);
  assign is_multu  = is_r & (bus.func == FnMultu);
  assign is_div    = is_r & (bus.func == FnDiv);
  assign is_divu   = is_r & (bus.func == FnDivu);
  assign is_mfhi   = is_r & (bus.func == FnMfhi);
  assign is_mflo   = is_r & (bus.func == FnMflo);
  assign is_mthi   = is_r & (bus.func == FnMthi);
  assign is_mtlo   = is_r & (bus.func == FnMtlo);
  assign is_md     = is_mult | is_multu | is_div | is_divu;
  assign is_signed = is_mult | is_div;
  assign ex_ok     = bus.valid_e & ~bus.flush_e & (state_q == StIdle);
  // Gated by rst_n so stall drops the instant reset asserts, even with an op sitting in EX.
  assign start     = rst_n & ex_ok & is_md;

  always_comb begin
    bus.alucontrol = 3'b010;
    bus.shift      = 1'b0;
    case (bus.aluop)
      3'b001: bus.alucontrol = 3'b110;
      3'b011: bus.alucontrol = 3'b001;
      3'b100: bus.alucontrol = 3'b000;
      3'b101: bus.alucontrol = 3'b111;
      3'b010: begin
        case (bus.func)
          6'b000000: begin bus.alucontrol = 3'b011; bus.shift = 1'b1; end
          6'b100000: bus.alucontrol = 3'b010;
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          6'b000100: bus.alucontrol = 3'b011;
          6'b000011: begin bus.alucontrol = 3'b100; bus.shift = 1'b1; end
          6'b000111: bus.alucontrol = 3'b100;
          6'b000010: begin bus.alucontrol = 3'b101; bus.shift = 1'b1; end
          6'b000110: bus.alucontrol = 3'b101;
          FnMult, FnMultu, FnDiv, FnDivu,
          FnMfhi, FnMflo, FnMthi, FnMtlo: bus.alucontrol = 3'b010;
          default: bus.alucontrol = 3'b011;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end

  // Operand magnitudes; |MIN| wraps to MIN, which is the correct unsigned magnitude.
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign sgn_a = is_signed & bus.srca[WIDTH-1];
  assign sgn_b = is_signed & bus.srcb[WIDTH-1];
  assign abs_a = sgn_a ? -bus.srca : bus.srca;
  assign abs_b = sgn_b ? -bus.srcb : bus.srcb;

  // Multiply step: acc = {carry, partial product, remaining multiplier bits}.
  logic [WIDTH:0]  mul_sum;
  logic [AccW-1:0] mul_next;

  assign mul_sum  = acc_q[AccW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:0]} >> 1;

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  logic [AccW-1:0] div_sh, div_next;
  logic [WIDTH:0]  div_top, div_diff;

  assign div_sh   = {acc_q[AccW-2:0], 1'b0};
  assign div_top  = div_sh[AccW-1:WIDTH];
  assign div_diff = div_top - {1'b0, opnd_q};
  assign div_next = (div_top >= {1'b0, opnd_q}) ? {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh;

  // Sign fix-up; a zero divisor leaves remainder = |srca|, so re-signing it restores srca.
  logic               neg, dz;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [AccW-1:0]    acc_fix;

  assign neg      = sa_q ^ sb_q;
  assign dz       = (opnd_q == '0);
  assign prod_fix = neg ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quo_fix  = dz ? '1 : (neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign acc_fix  = is_div_q ? {1'b0, rem_fix, quo_fix} : {1'b0, prod_fix};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StCalc;
            count_q  <= '0;
            acc_q    <= {{(WIDTH + 1){1'b0}}, abs_a};
            opnd_q   <= abs_b;
            is_div_q <= is_div | is_divu;
            sa_q     <= sgn_a;
            sb_q     <= sgn_b;
          end else if (ex_ok && is_mthi) begin
            hi_q <= bus.srca;
          end else if (ex_ok && is_mtlo) begin
            lo_q <= bus.srca;
          end
        end
        StCalc: begin
          if (bus.flush_e) begin
            state_q <= StIdle;
          end else begin
            acc_q   <= is_div_q ? div_next : mul_next;
            count_q <= count_q + CntW'(1);
            if (count_q == CntW'(WIDTH - 1)) state_q <= StFix;
          end
        end
        StFix: begin
          if (bus.flush_e) begin
            state_q <= StIdle;
          end else begin
            acc_q   <= acc_fix;
            state_q <= StDone;
          end
        end
        StDone: begin
          hi_q    <= acc_q[2*WIDTH-1:WIDTH];
          lo_q    <= acc_q[WIDTH-1:0];
          state_q <= StIdle;
        end
      endcase
    end
  end

  // DONE bypass lets an MF in EX see the value being written this cycle.
  logic [WIDTH-1:0] hi_view, lo_view;

  assign hi_view = (state_q == StDone) ? acc_q[2*WIDTH-1:WIDTH] : hi_q;
  assign lo_view = (state_q == StDone) ? acc_q[WIDTH-1:0] : lo_q;

  always_comb begin
    bus.mf_sel    = is_mfhi | is_mflo;
    bus.mf_result = '0;
    if (is_mfhi) bus.mf_result = hi_view;
    else if (is_mflo) bus.mf_result = lo_view;
  end

  assign bus.stall_e     = start | (state_q == StCalc) | (state_q == StFix);
  assign bus.md_busy     = (state_q != StIdle);
  assign bus.div_by_zero = (state_q == StDone) & is_div_q & dz;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
